// File: rtl/j11_mem_arb.sv
// j11_mem_arb: two-port round-robin arbiter in front of the single downstream memory bus.
//
// Port A (CPU memory path) and port B (DMA/peripheral master) each present a level request
// that is held until the port sees its ack or err pulse. The winning request is registered
// onto the dmem bus one clock after it is first sampled. The bus cycle is held until dmemack,
// or until TIMEOUT clocks pass without an answer (non-existent memory). In that case the
// granted port gets an err pulse instead of an ack pulse.
//
// Ports
//   clk_i, rstn_i                   clock, synchronous active-low reset
//   areq_i/awr_i/aaddr_i/awdata_i   port A request, direction, address, write data
//   aack_o/aerr_o/ardata_o          port A completion pulse, timeout pulse, read data
//   breq_i ... brdata_o             same for port B
//   dmemreq_o/dmemwr_o/dmemaddr_o/dmemwdata_o   registered bus request fields
//   dmemack_i/dmemrdata_i           bus completion pulse and read data
//
// Parameter
//   TIMEOUT  clocks of unanswered dmemreq before abort; 0 disables the timeout
module j11_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        areq_i,
    input  logic        awr_i,
    input  logic [21:0] aaddr_i,
    input  logic [15:0] awdata_i,
    output logic        aack_o,
    output logic        aerr_o,
    output logic [15:0] ardata_o,
    input  logic        breq_i,
    input  logic        bwr_i,
    input  logic [21:0] baddr_i,
    input  logic [15:0] bwdata_i,
    output logic        back_o,
    output logic        berr_o,
    output logic [15:0] brdata_o,
    output logic        dmemreq_o,
    output logic        dmemwr_o,
    output logic [21:0] dmemaddr_o,
    output logic [15:0] dmemwdata_o,
    input  logic        dmemack_i,
    input  logic [15:0] dmemrdata_i
);

    localparam int unsigned CW = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1));
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSA = 2'd1,
        ST_BUSB = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;          // 0: A wins a tie, 1: B wins a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dmemreq_q, dmemreq_d;
    logic          dmemwr_q, dmemwr_d;
    logic [21:0]   dmemaddr_q, dmemaddr_d;
    logic [15:0]   dmemwdata_q, dmemwdata_d;
    logic          aack_q, aack_d, aerr_q, aerr_d;
    logic          back_q, back_d, berr_q, berr_d;
    logic [15:0]   ardata_q, ardata_d, brdata_q, brdata_d;
    logic          grant_b_s;
    logic          tmo_hit_s;

    // Timeout fires on the last counted clock; disabled entirely when TIMEOUT is 0.
    always_comb begin
        tmo_hit_s = (TIMEOUT != 32'd0) && (cnt_q == CNT_LAST);
    end

    // Next-state, arbitration and bus/response register inputs.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        dmemreq_d   = dmemreq_q;
        dmemwr_d    = dmemwr_q;
        dmemaddr_d  = dmemaddr_q;
        dmemwdata_d = dmemwdata_q;
        ardata_d    = ardata_q;
        brdata_d    = brdata_q;
        aack_d      = 1'b0;
        aerr_d      = 1'b0;
        back_d      = 1'b0;
        berr_d      = 1'b0;
        grant_b_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (areq_i || breq_i) begin
                    // B wins when it is alone, or when both ask and B holds priority.
                    grant_b_s   = breq_i && (!areq_i || prio_q);
                    dmemreq_d   = 1'b1;
                    dmemwr_d    = grant_b_s ? bwr_i    : awr_i;
                    dmemaddr_d  = grant_b_s ? baddr_i  : aaddr_i;
                    dmemwdata_d = grant_b_s ? bwdata_i : awdata_i;
                    cnt_d       = {CW{1'b0}};
                    state_d     = grant_b_s ? ST_BUSB : ST_BUSA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSA, ST_BUSB: begin
                if (dmemack_i) begin
                    dmemreq_d = 1'b0;
                    state_d   = ST_DONE;
                    if (state_q == ST_BUSB) begin
                        back_d   = 1'b1;
                        brdata_d = dmemrdata_i;
                        prio_d   = 1'b0;
                    end else begin
                        aack_d   = 1'b1;
                        ardata_d = dmemrdata_i;
                        prio_d   = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    dmemreq_d = 1'b0;
                    state_d   = ST_DONE;
                    if (state_q == ST_BUSB) begin
                        berr_d = 1'b1;
                        prio_d = 1'b0;
                    end else begin
                        aerr_d = 1'b1;
                        prio_d = 1'b1;
                    end
                end else begin
                    // Saturate rather than wrap so a disabled timeout never aliases.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                dmemreq_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            dmemreq_q   <= 1'b0;
            dmemwr_q    <= 1'b0;
            dmemaddr_q  <= 22'd0;
            dmemwdata_q <= 16'd0;
            aack_q      <= 1'b0;
            aerr_q      <= 1'b0;
            back_q      <= 1'b0;
            berr_q      <= 1'b0;
            ardata_q    <= 16'd0;
            brdata_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            dmemreq_q   <= dmemreq_d;
            dmemwr_q    <= dmemwr_d;
            dmemaddr_q  <= dmemaddr_d;
            dmemwdata_q <= dmemwdata_d;
            aack_q      <= aack_d;
            aerr_q      <= aerr_d;
            back_q      <= back_d;
            berr_q      <= berr_d;
            ardata_q    <= ardata_d;
            brdata_q    <= brdata_d;
        end
    end

    assign dmemreq_o   = dmemreq_q;
    assign dmemwr_o    = dmemwr_q;
    assign dmemaddr_o  = dmemaddr_q;
    assign dmemwdata_o = dmemwdata_q;
    assign aack_o      = aack_q;
    assign aerr_o      = aerr_q;
    assign ardata_o    = ardata_q;
    assign back_o      = back_q;
    assign berr_o      = berr_q;
    assign brdata_o    = brdata_q;

endmodule
